// File: rtl/bcd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_ctrl_pkg
// Description : Shared types and helpers for the BCD timer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_valid_bcd(input logic [3:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : One decade counter digit with clear, load and count enable.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
    import bcd_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             en,
    output logic [BCD_W-1:0] q,
    output logic             at_max
);

    logic [BCD_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= ld_val;
        end else if (en) begin
            r_q <= (r_q == BCD_MAX) ? '0 : r_q + 4'd1;
        end
    end

    assign q      = r_q;
    assign at_max = (r_q == BCD_MAX);

endmodule
`default_nettype wire

// File: rtl/bcd_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter_ctrl
// Description : Start/stop/clear/preload timer over a cascade of BCD digits.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10,
    parameter bit WRAP     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  load_valid,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic                  load_ready,
    output logic                  load_err,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  tick,
    output logic                  running,
    output logic                  overflow,
    output logic                  done
);

    localparam int                c_PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_PS_W-1:0]   r_presc;
    logic                r_tick, r_load_err, r_overflow, r_running, r_done, r_load_ready;

    logic [DIGITS-1:0]   w_at_max;
    logic [DIGITS-1:0]   w_en;
    logic [DIGITS-1:0]   w_nib_ok;
    logic                w_all9, w_term, w_adv, w_inc;
    logic                w_load_req, w_ld;

    // A load request (good or bad) outranks stop/start; clear outranks it.
    assign w_load_req = load_valid && (r_state != RUN) && !clear;
    assign w_ld       = w_load_req && (&w_nib_ok);
    assign w_all9     = &w_at_max;
    assign w_term     = (r_state == RUN) && (r_presc == c_PS_LAST);
    assign w_adv      = w_term && !clear && !stop;
    assign w_inc      = w_adv && (WRAP || !w_all9);

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            assign w_nib_ok[k] = is_valid_bcd(load_value[k*BCD_W +: BCD_W]);

            if (k == 0) begin : g_lsd
                assign w_en[k] = w_inc;
            end else begin : g_carry
                assign w_en[k] = w_inc && (&w_at_max[k-1:0]);
            end

            bcd_digit u_digit (
                .clk    (clk),
                .reset  (reset),
                .clr    (clear),
                .ld     (w_ld),
                .ld_val (load_value[k*BCD_W +: BCD_W]),
                .en     (w_en[k]),
                .q      (count_bcd[k*BCD_W +: BCD_W]),
                .at_max (w_at_max[k])
            );
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else if (w_load_req) begin
            if (w_ld && (r_state == DONE)) w_state_nxt = PAUSED;
        end else begin
            case (r_state)
                IDLE:    if (start && !stop) w_state_nxt = RUN;
                RUN: begin
                    if (stop)                          w_state_nxt = PAUSED;
                    else if (w_term && w_all9 && !WRAP) w_state_nxt = DONE;
                end
                PAUSED:  if (start && !stop) w_state_nxt = RUN;
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_presc      <= '0;
            r_tick       <= 1'b0;
            r_load_err   <= 1'b0;
            r_overflow   <= 1'b0;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_tick       <= w_inc;
            r_load_err   <= w_load_req && !(&w_nib_ok);
            r_running    <= (w_state_nxt == RUN);
            r_done       <= (w_state_nxt == DONE);
            r_load_ready <= (w_state_nxt != RUN);

            if (clear)                 r_overflow <= 1'b0;
            else if (w_adv && w_all9)  r_overflow <= 1'b1;

            // Pausing freezes the prescaler so a resume keeps the partial period.
            if (clear || w_ld)                                  r_presc <= '0;
            else if ((r_state == IDLE) && (w_state_nxt == RUN)) r_presc <= '0;
            else if ((r_state == RUN) && !stop)                 r_presc <= w_term ? '0 : r_presc + c_PS_W'(1);
        end
    end

    assign tick       = r_tick;
    assign load_err   = r_load_err;
    assign overflow   = r_overflow;
    assign running    = r_running;
    assign done       = r_done;
    assign load_ready = r_load_ready;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_counter_ctrl
// Description : Scoreboard bench; instance 0 wraps, instance 1 saturates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_ctrl;

    localparam int c_P    = 4;
    localparam int c_MAXV = 9999;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;

    typedef struct packed {
        logic        inst;
        logic        err;
        logic [15:0] cnt;
    } ev_t;

    logic        clk;
    logic        reset, start, stop, clear, load_valid;
    logic [15:0] load_value;
    logic [1:0]  rdy, er, tk, run, ov, dn;
    logic [15:0] cnt [2];

    int  m_count [2];
    int  m_presc [2];
    int  m_state [2];
    bit  m_ovf   [2];
    bit  m_live;
    ev_t sb [$];
    int  n_tests, n_fail;

    bcd_counter_ctrl #(.DIGITS(4), .PRESCALE(c_P), .WRAP(1'b1)) u_dut_wrap (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .load_valid(load_valid), .load_value(load_value), .load_ready(rdy[0]),
        .load_err(er[0]), .count_bcd(cnt[0]), .tick(tk[0]), .running(run[0]),
        .overflow(ov[0]), .done(dn[0])
    );

    bcd_counter_ctrl #(.DIGITS(4), .PRESCALE(c_P), .WRAP(1'b0)) u_dut_sat (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .load_valid(load_valid), .load_value(load_value), .load_ready(rdy[1]),
        .load_err(er[1]), .count_bcd(cnt[1]), .tick(tk[1]), .running(run[1]),
        .overflow(ov[1]), .done(dn[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        int r;
        r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(b[i*4 +: 4]);
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [15:0] b);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (b[i*4 +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    // Reference: integer count and a four-state timer, advanced once per clock.
    task automatic model_step();
        ev_t e;
        bit  wrap, tkx, erx;
        for (int i = 0; i < 2; i++) begin
            wrap = (i == 0);
            tkx  = 1'b0;
            erx  = 1'b0;
            if (reset) begin
                m_count[i] = 0; m_presc[i] = 0; m_state[i] = S_IDLE; m_ovf[i] = 1'b0;
            end else if (clear) begin
                m_count[i] = 0; m_presc[i] = 0; m_state[i] = S_IDLE; m_ovf[i] = 1'b0;
            end else if (load_valid && m_state[i] != S_RUN) begin
                if (bcd_ok(load_value)) begin
                    m_count[i] = from_bcd(load_value);
                    m_presc[i] = 0;
                    if (m_state[i] == S_DONE) m_state[i] = S_PAUSED;
                end else begin
                    erx = 1'b1;
                end
            end else begin
                case (m_state[i])
                    S_IDLE:   if (start && !stop) begin m_state[i] = S_RUN; m_presc[i] = 0; end
                    S_PAUSED: if (start && !stop) m_state[i] = S_RUN;
                    S_RUN: begin
                        if (stop) begin
                            m_state[i] = S_PAUSED;
                        end else if (m_presc[i] == c_P - 1) begin
                            m_presc[i] = 0;
                            if (m_count[i] == c_MAXV) begin
                                m_ovf[i] = 1'b1;
                                if (wrap) begin m_count[i] = 0; tkx = 1'b1; end
                                else      m_state[i] = S_DONE;
                            end else begin
                                m_count[i] = m_count[i] + 1;
                                tkx = 1'b1;
                            end
                        end else begin
                            m_presc[i] = m_presc[i] + 1;
                        end
                    end
                    default: ;
                endcase
            end
            if (tkx) begin e.inst = 1'(i); e.err = 1'b0; e.cnt = to_bcd(m_count[i]); sb.push_back(e); end
            if (erx) begin e.inst = 1'(i); e.err = 1'b1; e.cnt = to_bcd(m_count[i]); sb.push_back(e); end
        end
        if (reset) m_live = 1'b1;
    endtask

    task automatic cyc(input logic st, input logic sp, input logic cl, input logic lv,
                       input logic [15:0] val, input logic rs);
        @(negedge clk);
        start = st; stop = sp; clear = cl; load_valid = lv; load_value = val; reset = rs;
        model_step();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    // Monitor: status every cycle, plus tick/load_err events against the scoreboard.
    always begin : mon
        ev_t obs, exp_e;
        logic [19:0] st_got, st_exp;
        @(posedge clk);
        #1;
        if (m_live) begin
            for (int i = 0; i < 2; i++) begin
                st_got = {cnt[i], run[i], dn[i], rdy[i], ov[i]};
                st_exp = {to_bcd(m_count[i]), m_state[i] == S_RUN, m_state[i] == S_DONE,
                          m_state[i] != S_RUN, m_ovf[i]};
                n_tests++;
                if (st_got !== st_exp) begin
                    n_fail++;
                    $display("FAIL status inst%0d got %h exp %h (count,run,done,ready,ovf)", i, st_got, st_exp);
                end
                for (int k = 0; k < 2; k++) begin
                    if ((k == 0) ? (tk[i] === 1'b1) : (er[i] === 1'b1)) begin
                        obs.inst = 1'(i); obs.err = 1'(k); obs.cnt = cnt[i];
                        n_tests++;
                        if (sb.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_event inst%0d err=%0d got count %h exp none", i, k, cnt[i]);
                        end else begin
                            exp_e = sb.pop_front();
                            if (obs !== exp_e) begin
                                n_fail++;
                                $display("FAIL event got %h exp %h (inst,err,count)", obs, exp_e);
                            end
                        end
                    end
                end
            end
            while (sb.size() > 0) begin
                exp_e = sb.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_event got none exp %h (inst,err,count)", exp_e);
            end
        end
    end

    initial begin
        n_tests = 0; n_fail = 0; m_live = 1'b0;
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        load_valid = 1'b0; load_value = 16'h0000;

        cyc(0, 0, 0, 0, 16'h0000, 1); cyc(0, 0, 0, 0, 16'h0000, 1); idle(1);
        cyc(1, 0, 0, 0, 16'h0000, 0); idle(10);                         // 1, 2 ticks
        cyc(0, 0, 1, 0, 16'h0000, 0); cyc(0, 0, 0, 1, 16'h0099, 0);
        cyc(1, 0, 0, 0, 16'h0000, 0); idle(5);                          // 0099 -> 0100
        cyc(0, 1, 0, 0, 16'h0000, 0); cyc(0, 0, 0, 1, 16'h1239, 0);
        cyc(1, 0, 0, 0, 16'h0000, 0); idle(5);                          // 1239 -> 1240
        cyc(0, 1, 0, 0, 16'h0000, 0); cyc(0, 0, 0, 1, 16'h9999, 0);
        cyc(1, 0, 0, 0, 16'h0000, 0); idle(6);                          // wrap vs saturate
        cyc(1, 0, 0, 0, 16'h0000, 0); cyc(0, 1, 0, 0, 16'h0000, 0); idle(2);
        cyc(0, 0, 1, 0, 16'h0000, 0); cyc(1, 0, 0, 0, 16'h0000, 0); idle(2);
        cyc(0, 1, 0, 0, 16'h0000, 0); idle(10);                         // pause at prescaler 2
        cyc(1, 0, 0, 0, 16'h0000, 0); idle(4);
        cyc(1, 1, 0, 0, 16'h0000, 0); idle(2);                          // stop beats start
        cyc(0, 0, 0, 1, 16'h12A4, 0); idle(1);                          // rejected load
        cyc(1, 0, 0, 0, 16'h0000, 0); cyc(0, 0, 0, 1, 16'h5555, 0); idle(2);
        cyc(0, 0, 1, 0, 16'h0000, 0); cyc(1, 0, 0, 0, 16'h0000, 0); idle(3);
        cyc(0, 0, 1, 0, 16'h0000, 0); idle(2);                          // clear on terminal count
        cyc(1, 0, 0, 0, 16'h0000, 0); idle(6);
        cyc(0, 0, 0, 0, 16'h0000, 1); idle(2);                          // reset mid-run

        for (int c = 0; c < 3000; c++) begin
            int r;
            logic [15:0] v;
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 2) == 0) v = to_bcd(9990 + int'($urandom_range(0, 9)));
            else                           v = to_bcd(int'($urandom_range(0, c_MAXV)));
            if ($urandom_range(0, 7) == 0) v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            cyc(r < 25, (r >= 20) && (r < 30), r == 40, (r >= 50) && (r < 55), v, r == 99);
        end

        idle(2);
        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
